// File: rtl/motor_speed_ramp_ctrl.sv
// Sole writer of the motor speed register: ramps toward an accepted target in STEP-sized writes spaced DIV cycles apart.
// First write lands 2 cycles after acceptance; new targets are refused until idle; estop overrides everything with a write of 0.
module motor_speed_ramp_ctrl #(
  parameter int DATA_W = 16,
  parameter int STEP   = 64,
  parameter int DIV    = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [DATA_W-1:0] req_data,
  output logic              req_ready,
  input  logic              estop,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_we,
  output logic [DATA_W-1:0] level,
  output logic [DATA_W-1:0] target,
  output logic              busy
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_STEP  = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_ESTOP = 2'd3;

  localparam logic [DATA_W-1:0] STEP_V   = DATA_W'(STEP);
  localparam logic [CNT_W-1:0]  LAST_CNT = (DIV > 1) ? CNT_W'(DIV - 2) : '0;

  logic [1:0]        r_state;
  logic [DATA_W-1:0] r_level;
  logic [DATA_W-1:0] r_target;
  logic [DATA_W-1:0] r_wdata;
  logic              r_we;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_up;
  logic [DATA_W-1:0] w_diff;
  logic [DATA_W-1:0] w_next;
  logic              w_accept;

  // The clamp to target keeps next between level and target, so the +/- STEP cannot wrap.
  always_comb begin
    w_up   = r_target > r_level;
    w_diff = w_up ? (r_target - r_level) : (r_level - r_target);
    if (w_diff <= STEP_V)
      w_next = r_target;
    else if (w_up)
      w_next = r_level + STEP_V;
    else
      w_next = r_level - STEP_V;
  end

  assign req_ready = (r_state == ST_IDLE) & ~estop & ~rst;
  assign w_accept  = req_valid & req_ready;
  assign busy      = (r_state != ST_IDLE);
  assign reg_wdata = r_wdata;
  assign reg_we    = r_we;
  assign level     = r_level;
  assign target    = r_target;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_level  <= '0;
      r_target <= '0;
      r_wdata  <= '0;
      r_we     <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_we <= 1'b0;
      if (estop && (r_state != ST_ESTOP)) begin
        r_state  <= ST_ESTOP;
        r_we     <= 1'b1;
        r_wdata  <= '0;
        r_level  <= '0;
        r_target <= '0;
        r_cnt    <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_accept) begin
              r_target <= req_data;
              if (req_data != r_level)
                r_state <= ST_STEP;
            end
          end
          ST_STEP: begin
            r_we    <= 1'b1;
            r_wdata <= w_next;
            r_level <= w_next;
            r_cnt   <= '0;
            if (w_next == r_target)
              r_state <= ST_IDLE;
            else if (DIV == 1)
              r_state <= ST_STEP;
            else
              r_state <= ST_WAIT;
          end
          ST_WAIT: begin
            if (r_cnt == LAST_CNT)
              r_state <= ST_STEP;
            else
              r_cnt <= r_cnt + 1'b1;
          end
          default: begin
            if (!estop)
              r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_motor_speed_ramp_ctrl.sv
module tb_motor_speed_ramp_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, estop;
  logic [15:0] req_data;
  logic        req_ready, reg_we, busy;
  logic [15:0] reg_wdata, level, target;

  logic        req_valid2;
  logic [15:0] req_data2;
  logic        req_ready2, reg_we2, busy2;
  logic [15:0] reg_wdata2, level2, target2;
  logic        estop2;

  int n_cmp = 0;
  int n_bad = 0;
  int wr_q[$];
  int wr_cyc[$];

  always #5 clk = ~clk;

  motor_speed_ramp_ctrl #(.DATA_W(16), .STEP(64), .DIV(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .estop(estop), .reg_wdata(reg_wdata),
    .reg_we(reg_we), .level(level), .target(target), .busy(busy));

  motor_speed_ramp_ctrl #(.DATA_W(16), .STEP(64), .DIV(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid2), .req_data(req_data2),
    .req_ready(req_ready2), .estop(estop2), .reg_wdata(reg_wdata2),
    .reg_we(reg_we2), .level(level2), .target(target2), .busy(busy2));

  typedef struct {
    logic [15:0]       req;
    int                n;
    logic [4:0][15:0]  w;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Handshake one request, then record every write until the controller is idle.
  // wr_cyc holds the negedge index after the accepting edge at which reg_we was seen.
  task automatic run_req(input logic [15:0] d, input int budget);
    int cyc;
    wr_q.delete();
    wr_cyc.delete();
    @(negedge clk);
    chk("ready_before_req", req_ready, 1);
    req_valid = 1'b1;
    req_data  = d;
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 1;
    forever begin
      if (reg_we) begin
        wr_q.push_back(int'(reg_wdata));
        wr_cyc.push_back(cyc);
      end
      if (!busy) break;
      if (cyc >= budget) begin
        chk("ramp_timeout", cyc, budget + 1);
        break;
      end
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    int accepts, bad_ready, drop, cyc, nw, seen;
    vecs[0] = '{16'd300,   5, {16'd300, 16'd256, 16'd192, 16'd128, 16'd64}};
    vecs[1] = '{16'd10,    5, {16'd10,  16'd44,  16'd108, 16'd172, 16'd236}};
    vecs[2] = '{16'd10,    0, {16'd0,   16'd0,   16'd0,   16'd0,   16'd0}};
    vecs[3] = '{16'd74,    1, {16'd0,   16'd0,   16'd0,   16'd0,   16'd74}};
    vecs[4] = '{16'd0,     2, {16'd0,   16'd0,   16'd0,   16'd0,   16'd10}};
    vecs[5] = '{16'd65,    2, {16'd0,   16'd0,   16'd0,   16'd65,  16'd64}};

    rst = 1'b1; req_valid = 1'b0; req_data = '0; estop = 1'b0;
    req_valid2 = 1'b0; req_data2 = '0; estop2 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", req_ready, 0);
    chk("rst_we", reg_we, 0);
    chk("rst_level", level, 0);
    chk("rst_target", target, 0);
    chk("rst_wdata", reg_wdata, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;

    // Table-driven ramps, each starting from where the previous one ended.
    for (int v = 0; v < 6; v++) begin
      run_req(vecs[v].req, 200);
      chk($sformatf("v%0d_nwrites", v), wr_q.size(), vecs[v].n);
      for (int i = 0; i < wr_q.size() && i < vecs[v].n; i++) begin
        chk($sformatf("v%0d_wdata%0d", v, i), wr_q[i], vecs[v].w[i]);
        chk($sformatf("v%0d_cycle%0d", v, i), wr_cyc[i], 2 + 4 * i);
      end
      chk($sformatf("v%0d_level", v), level, vecs[v].req);
      chk($sformatf("v%0d_target", v), target, vecs[v].req);
      chk($sformatf("v%0d_busy", v), busy, 0);
      chk($sformatf("v%0d_ready", v), req_ready, 1);
      @(negedge clk);
      chk($sformatf("v%0d_we_low", v), reg_we, 0);
      if (vecs[v].n > 0)
        chk($sformatf("v%0d_wdata_hold", v), reg_wdata, vecs[v].req);
    end

    // Reset mid-ramp at level 192.
    @(negedge clk); rst = 1'b1; @(negedge clk); rst = 1'b0;
    req_valid = 1'b1; req_data = 16'd300;
    @(negedge clk); req_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (reg_we && reg_wdata == 16'd192) seen = 1;
    end
    chk("rst_mid_reached192", seen, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_level", level, 0);
    chk("rst_mid_target", target, 0);
    chk("rst_mid_wdata", reg_wdata, 0);
    chk("rst_mid_we", reg_we, 0);
    chk("rst_mid_busy", busy, 0);
    rst = 1'b0;
    nw = 0;
    repeat (10) begin @(negedge clk); if (reg_we) nw++; end
    chk("rst_mid_no_writes", nw, 0);

    // Estop after the 128 write of a 0->300 ramp.
    req_valid = 1'b1; req_data = 16'd300;
    @(negedge clk); req_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (reg_we && reg_wdata == 16'd128) seen = 1;
    end
    chk("estop_reached128", seen, 1);
    estop = 1'b1;
    @(negedge clk);
    chk("estop_we", reg_we, 1);
    chk("estop_wdata", reg_wdata, 0);
    chk("estop_level", level, 0);
    chk("estop_target", target, 0);
    chk("estop_busy", busy, 1);
    nw = 0; bad_ready = 0;
    repeat (6) begin @(negedge clk); if (reg_we) nw++; if (req_ready) bad_ready++; end
    chk("estop_no_writes", nw, 0);
    chk("estop_ready_low", bad_ready, 0);
    estop = 1'b0; req_valid = 1'b1; req_data = 16'd64;
    @(negedge clk);
    chk("estop_rel_busy", busy, 0);
    chk("estop_rel_not_accepted", target, 0);
    chk("estop_rel_no_write", reg_we, 0);
    req_valid = 1'b0;
    run_req(16'd64, 50);
    chk("estop_after_nwrites", wr_q.size(), 1);
    if (wr_q.size() > 0) chk("estop_after_wdata", wr_q[0], 64);

    // Request 500 held valid during a 64->300 ramp: accepted exactly once when idle.
    @(negedge clk);
    req_valid = 1'b1; req_data = 16'd300;
    @(negedge clk);
    req_data = 16'd500;
    wr_q.delete();
    accepts = 0; bad_ready = 0; drop = 0; cyc = 0;
    forever begin
      if (drop) begin req_valid = 1'b0; drop = 0; end
      if (reg_we) wr_q.push_back(int'(reg_wdata));
      if (req_ready && busy) bad_ready++;
      if (req_valid && req_ready) begin accepts++; drop = 1; end
      if (accepts > 0 && !drop && !busy) break;
      if (cyc > 200) begin chk("held_timeout", cyc, 0); break; end
      @(negedge clk);
      cyc++;
    end
    req_valid = 1'b0;
    chk("held_accepts", accepts, 1);
    chk("held_ready_busy", bad_ready, 0);
    chk("held_nwrites", wr_q.size(), 8);
    if (wr_q.size() == 8) begin
      chk("held_w3", wr_q[3], 300);
      chk("held_w4", wr_q[4], 364);
      chk("held_w7", wr_q[7], 500);
    end
    chk("held_level", level, 500);

    // DIV=1 instance: full-scale ramp with back-to-back writes.
    @(negedge clk);
    req_valid2 = 1'b1; req_data2 = 16'hFFFF;
    @(negedge clk);
    req_valid2 = 1'b0;
    wr_q.delete(); wr_cyc.delete();
    cyc = 1;
    forever begin
      if (reg_we2) begin wr_q.push_back(int'(reg_wdata2)); wr_cyc.push_back(cyc); end
      if (!busy2) break;
      if (cyc > 3000) begin chk("div1_timeout", cyc, 0); break; end
      @(negedge clk);
      cyc++;
    end
    chk("div1_nwrites", wr_q.size(), 1024);
    if (wr_q.size() == 1024) begin
      nw = 0;
      for (int i = 0; i < 1023; i++)
        if (wr_q[i] != 64 * (i + 1) || wr_cyc[i] != i + 2) nw++;
      chk("div1_sequence_errs", nw, 0);
      chk("div1_w1022", wr_q[1022], 65472);
      chk("div1_w1023", wr_q[1023], 65535);
      chk("div1_last_cycle", wr_cyc[1023], 1025);
    end
    chk("div1_level", level2, 65535);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
